// File: rtl/imu_pkg.sv
// imu_pkg: shared types and constants for the IMU SPI sequencer.
//   state_t  - sequencer FSM states (each SPI access is an ISS/WT pair)
//   CMD_*    - SPI command words issued by the sequencer
//   is_issue - true in states that pulse wrt
//   cmd_of   - command word driven in a given state (0 outside issue states)
package imu_pkg;

    typedef enum logic [3:0] {
        PWR,
        CFG1_ISS, CFG1_WT,
        CFG2_ISS, CFG2_WT,
        CFG3_ISS, CFG3_WT,
        IDLE,
        RD_YL_ISS, RD_YL_WT,
        RD_YH_ISS, RD_YH_WT
    } state_t;

    localparam logic [15:0] CMD_INT_CFG   = 16'h0D02;  // INT on data ready
    localparam logic [15:0] CMD_GYRO_CFG  = 16'h1160;  // gyro 416Hz, 245dps
    localparam logic [15:0] CMD_ROUND_CFG = 16'h1440;  // rounding on
    localparam logic [15:0] CMD_YAWL_RD   = 16'hA600;
    localparam logic [15:0] CMD_YAWH_RD   = 16'hA700;

    function automatic logic is_issue(input state_t s);
        return (s == CFG1_ISS) || (s == CFG2_ISS) || (s == CFG3_ISS) ||
               (s == RD_YL_ISS) || (s == RD_YH_ISS);
    endfunction

    function automatic logic [15:0] cmd_of(input state_t s);
        case (s)
            CFG1_ISS:  return CMD_INT_CFG;
            CFG2_ISS:  return CMD_GYRO_CFG;
            CFG3_ISS:  return CMD_ROUND_CFG;
            RD_YL_ISS: return CMD_YAWL_RD;
            RD_YH_ISS: return CMD_YAWH_RD;
            default:   return 16'h0000;
        endcase
    endfunction

endpackage

// File: rtl/int_sync.sv
// int_sync: 2-flop synchronizer for an asynchronous level plus rising-edge detect.
//   clk, rst_n - clock, asynchronous active-low reset (all flops clear to 0)
//   async_in   - asynchronous input level
//   rise       - one-cycle pulse on a rising edge of the synchronized level
module int_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic rise
);

    logic int_ff1, int_ff2, int_ff3;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            int_ff1 <= 1'b0;
            int_ff2 <= 1'b0;
            int_ff3 <= 1'b0;
        end else begin
            int_ff1 <= async_in;
            int_ff2 <= int_ff1;
            int_ff3 <= int_ff2;
        end
    end

    assign rise = int_ff2 & ~int_ff3;

endmodule

// File: rtl/imu_spi_seq.sv
// imu_spi_seq: sequencer for the SPI monarch talking to the inertial sensor.
// Waits PWR_WAIT cycles after reset, writes three config words, then on each
// data-ready interrupt reads yaw-rate low/high bytes and presents yaw_rt/vld.
//   clk, rst_n      - 50MHz clock, asynchronous active-low reset
//   INT             - asynchronous data-ready interrupt (active high)
//   done, rd_data   - SPI monarch completion flag (held until next wrt), read byte in [7:0]
//   wrt, cmd        - one-cycle SPI start pulse and its command word
//   yaw_rt, vld     - signed yaw rate and its one-cycle update strobe
//   err             - one-cycle SPI timeout pulse
// Optional macro IMU_SPI_TMO_EN: enables a per-transaction timeout of TMO_CYC
// cycles; without it err is tied low and waits are unbounded.
module imu_spi_seq
    import imu_pkg::*;
#(
    parameter logic [15:0] PWR_WAIT = 16'hFFFF,
    parameter logic [11:0] TMO_CYC  = 12'd1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        INT,
    input  logic        done,
    input  logic [15:0] rd_data,
    output logic        wrt,
    output logic [15:0] cmd,
    output logic [15:0] yaw_rt,
    output logic        vld,
    output logic        err
);

    state_t      state;
    logic [15:0] pwr_cnt;
    logic [7:0]  yaw_l;
    logic        int_rise;
    logic        int_pend;
    logic        tmo_hit;
    logic        in_wait;

    int_sync u_int_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .async_in (INT),
        .rise     (int_rise)
    );

    // Outputs decode straight from state, so reset forces them low at once.
    assign wrt = is_issue(state);
    assign cmd = cmd_of(state);

    assign in_wait = (state == CFG1_WT) || (state == CFG2_WT) || (state == CFG3_WT) ||
                     (state == RD_YL_WT) || (state == RD_YH_WT);

`ifdef IMU_SPI_TMO_EN
    logic [11:0] tmo_cnt;

    assign tmo_hit = in_wait && !done && (tmo_cnt == TMO_CYC - 12'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt <= 12'd0;
            err     <= 1'b0;
        end else begin
            err     <= tmo_hit;
            tmo_cnt <= (in_wait && !tmo_hit) ? tmo_cnt + 12'd1 : 12'd0;
        end
    end
`else
    logic unused_tmo;
    assign unused_tmo = ^{TMO_CYC, in_wait};
    assign tmo_hit    = 1'b0;
    assign err        = 1'b0;
`endif

    logic unused_rd;
    assign unused_rd = ^rd_data[15:8];

    // A new edge wins over the clear so an edge coincident with RD_YL issue
    // still produces one more read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                  int_pend <= 1'b0;
        else if (int_rise)           int_pend <= 1'b1;
        else if (state == RD_YL_ISS) int_pend <= 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= PWR;
            pwr_cnt <= 16'd0;
            yaw_l   <= 8'd0;
            yaw_rt  <= 16'd0;
            vld     <= 1'b0;
        end else begin
            vld <= 1'b0;
            case (state)
                PWR: begin
                    if (pwr_cnt == PWR_WAIT - 16'd1) state <= CFG1_ISS;
                    else                             pwr_cnt <= pwr_cnt + 16'd1;
                end
                CFG1_ISS: state <= CFG1_WT;
                CFG1_WT:  if (done) state <= CFG2_ISS; else if (tmo_hit) state <= CFG1_ISS;
                CFG2_ISS: state <= CFG2_WT;
                CFG2_WT:  if (done) state <= CFG3_ISS; else if (tmo_hit) state <= CFG1_ISS;
                CFG3_ISS: state <= CFG3_WT;
                CFG3_WT:  if (done) state <= IDLE;     else if (tmo_hit) state <= CFG1_ISS;
                IDLE:     if (int_pend) state <= RD_YL_ISS;
                RD_YL_ISS: state <= RD_YL_WT;
                RD_YL_WT: begin
                    if (done) begin
                        yaw_l <= rd_data[7:0];
                        state <= RD_YH_ISS;
                    end else if (tmo_hit) begin
                        state <= IDLE;
                    end
                end
                RD_YH_ISS: state <= RD_YH_WT;
                RD_YH_WT: begin
                    if (done) begin
                        yaw_rt <= {rd_data[7:0], yaw_l};
                        vld    <= 1'b1;
                        state  <= IDLE;
                    end else if (tmo_hit) begin
                        state <= IDLE;
                    end
                end
                default: state <= PWR;
            endcase
        end
    end

endmodule

// File: tb/tb_imu_spi_seq.sv
// tb_imu_spi_seq: directed bench for imu_spi_seq with a small SPI monarch model.
// Power-up/config sequence, table of read vectors, INT during a read, reset
// mid-read with INT during PWR, and (with IMU_SPI_TMO_EN) a read timeout.
module tb_imu_spi_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        INT;
    logic        done;
    logic [15:0] rd_data;
    logic        wrt;
    logic [15:0] cmd;
    logic [15:0] yaw_rt;
    logic        vld;
    logic        err;

    imu_spi_seq #(.PWR_WAIT(16'd16), .TMO_CYC(12'd64)) dut (
        .clk(clk), .rst_n(rst_n), .INT(INT), .done(done), .rd_data(rd_data),
        .wrt(wrt), .cmd(cmd), .yaw_rt(yaw_rt), .vld(vld), .err(err)
    );

    always #10 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // model / monitor state
    logic [15:0] cmd_q[$];
    int          lat = 3;
    bit          hold_yl = 1'b0;
    logic [7:0]  rsp_lo = 8'h00, rsp_hi = 8'h00;
    int          vld_cnt = 0, err_cnt = 0, consec = 0;
    int          done_yh_cyc = 0, yl_wrt_cyc = 0, err_cyc = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [15:0] qat(input int i);
        if (cmd_q.size() > i) return cmd_q[i];
        return 16'hDEAD;
    endfunction

    // SPI monarch model and output monitor, both working on the falling edge.
    initial begin
        int         cnt;
        logic [15:0] last;
        bit         prev_wrt;
        cnt = 0; last = 16'h0; prev_wrt = 1'b0;
        done = 1'b0; rd_data = 16'h0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                done = 1'b0; cnt = 0; prev_wrt = 1'b0;
            end else begin
                if (wrt) begin
                    cmd_q.push_back(cmd);
                    if (prev_wrt) consec++;
                    if (cmd == 16'hA600) yl_wrt_cyc = cyc;
                end
                prev_wrt = wrt;
                if (vld) vld_cnt++;
                if (err) begin err_cnt++; err_cyc = cyc; end
                if (wrt) begin
                    done = 1'b0;
                    last = cmd;
                    cnt  = (hold_yl && cmd == 16'hA600) ? 0 : lat;
                end else if (cnt > 0) begin
                    cnt--;
                    if (cnt == 0) begin
                        done    = 1'b1;
                        rd_data = {8'hA5, (last == 16'hA600) ? rsp_lo :
                                          (last == 16'hA700) ? rsp_hi : 8'h00};
                        if (last == 16'hA700) done_yh_cyc = cyc;
                    end
                end
            end
        end
    end

    task automatic wait_q(input int n, input int budget, input string nm);
        for (int k = 0; k < budget; k++) begin
            if (cmd_q.size() >= n) break;
            @(negedge clk);
        end
        chk(nm, 32'(cmd_q.size() >= n), 32'd1);
    endtask

    // Release reset, expect 16 quiet clocks then the three config writes.
    task automatic powerup(input bit int_in_pwr);
        int n;
        cmd_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        while (n < 100) begin
            @(negedge clk);
            n++;
            if (int_in_pwr && n == 2) INT = 1'b1;
            if (n == 6) INT = 1'b0;
            if (wrt) break;
        end
        chk("pwr_wait", n, 16);
        wait_q(3, 300, "cfg_count");
        chk("cfg1", qat(0), 16'h0D02);
        chk("cfg2", qat(1), 16'h1160);
        chk("cfg3", qat(2), 16'h1440);
    endtask

    // Pulse INT and wait for vld, sampling on the falling edge.
    task automatic run_read(input string nm, output bit got);
        got = 1'b0;
        INT = 1'b1;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (k == 3) INT = 1'b0;
            if (vld) begin got = 1'b1; break; end
        end
        INT = 1'b0;
        chk({nm, "_vld_seen"}, 32'(got), 32'd1);
    endtask

    typedef struct {
        logic [7:0]  lo;
        logic [7:0]  hi;
        logic [15:0] exp;
    } vec_t;

    initial begin
        vec_t vt[5];
        bit   got;
        int   v0;

        vt[0] = '{8'h34, 8'h12, 16'h1234};
        vt[1] = '{8'hF0, 8'hFF, 16'hFFF0};
        vt[2] = '{8'h00, 8'h80, 16'h8000};
        vt[3] = '{8'hFF, 8'h7F, 16'h7FFF};
        vt[4] = '{8'h01, 8'h00, 16'h0001};

        rst_n = 1'b0;
        INT   = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_wrt", 32'(wrt), 0);
        chk("rst_cmd", 32'(cmd), 0);
        chk("rst_yaw", 32'(yaw_rt), 0);
        chk("rst_vld", 32'(vld), 0);
        chk("rst_err", 32'(err), 0);

        powerup(1'b0);
        repeat (10) @(negedge clk);

        for (int i = 0; i < 5; i++) begin
            cmd_q.delete();
            rsp_lo = vt[i].lo;
            rsp_hi = vt[i].hi;
            run_read($sformatf("vec%0d", i), got);
            chk($sformatf("vec%0d_yaw", i), 32'(yaw_rt), 32'(vt[i].exp));
            chk($sformatf("vec%0d_rdl", i), 32'(qat(0)), 32'h0000A600);
            chk($sformatf("vec%0d_rdh", i), 32'(qat(1)), 32'h0000A700);
            chk($sformatf("vec%0d_lat", i), cyc - done_yh_cyc, 1);
            @(negedge clk);
            chk($sformatf("vec%0d_vld_width", i), 32'(vld), 0);
            repeat (5) @(negedge clk);
        end

        // Three INT edges while RD_YH waits: exactly one extra read pair.
        lat = 20;
        cmd_q.delete();
        v0 = vld_cnt;
        rsp_lo = 8'h22; rsp_hi = 8'h11;
        INT = 1'b1;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (k == 3) INT = 1'b0;
            if (cmd_q.size() >= 2) break;
        end
        INT = 1'b0;
        for (int e = 0; e < 3; e++) begin
            INT = 1'b1; repeat (3) @(negedge clk);
            INT = 1'b0; repeat (3) @(negedge clk);
        end
        repeat (150) @(negedge clk);
        chk("multi_vld_cnt", vld_cnt - v0, 2);
        chk("multi_wrt_cnt", cmd_q.size(), 4);
        chk("multi_rdl2", 32'(qat(2)), 32'h0000A600);
        chk("multi_rdh2", 32'(qat(3)), 32'h0000A700);
        chk("multi_yaw", 32'(yaw_rt), 32'h00001122);

        // Reset while waiting on RD_YH, then INT during the power-up wait.
        cmd_q.delete();
        INT = 1'b1;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (k == 3) INT = 1'b0;
            if (cmd_q.size() >= 2) break;
        end
        INT = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_wrt", 32'(wrt), 0);
        chk("midrst_cmd", 32'(cmd), 0);
        chk("midrst_yaw", 32'(yaw_rt), 0);
        chk("midrst_vld", 32'(vld), 0);
        chk("midrst_err", 32'(err), 0);
        repeat (2) @(negedge clk);
        lat = 3;
        rsp_lo = 8'h9A; rsp_hi = 8'hBC;
        v0 = vld_cnt;
        powerup(1'b1);
        wait_q(5, 200, "pwr_int_count");
        chk("pwr_int_rdl", 32'(qat(3)), 32'h0000A600);
        chk("pwr_int_rdh", 32'(qat(4)), 32'h0000A700);
        for (int k = 0; k < 100; k++) begin
            if (vld_cnt > v0) break;
            @(negedge clk);
        end
        chk("pwr_int_vld", vld_cnt - v0, 1);
        chk("pwr_int_yaw", 32'(yaw_rt), 32'h0000BC9A);
        repeat (5) @(negedge clk);

`ifdef IMU_SPI_TMO_EN
        // done withheld on RD_YL: err after 64 wait cycles, no vld, back to IDLE.
        hold_yl = 1'b1;
        cmd_q.delete();
        v0 = vld_cnt;
        got = 1'b0;
        INT = 1'b1;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (k == 3) INT = 1'b0;
            if (err) begin got = 1'b1; break; end
        end
        INT = 1'b0;
        chk("tmo_err_seen", 32'(got), 1);
        chk("tmo_err_time", err_cyc - yl_wrt_cyc, 65);
        @(negedge clk);
        chk("tmo_err_width", 32'(err), 0);
        repeat (20) @(negedge clk);
        chk("tmo_no_vld", vld_cnt - v0, 0);
        chk("tmo_no_rdh", cmd_q.size(), 1);
        chk("tmo_yaw_kept", 32'(yaw_rt), 32'h0000BC9A);
        hold_yl = 1'b0;
        rsp_lo = 8'h78; rsp_hi = 8'h56;
        run_read("tmo_recover", got);
        chk("tmo_recover_yaw", 32'(yaw_rt), 32'h00005678);
        chk("err_total", err_cnt, 1);
`else
        chk("err_total", err_cnt, 0);
`endif
        chk("no_consec_wrt", consec, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
